// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package deserializer_pkg;

  typedef enum logic {
    RECEIVE = 1'b0,
    READY   = 1'b1
  } deser_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/deserializer.sv
// Collects DATA_WIDTH strobed serial bits MSB first and holds the finished word
// on data_out with data_ready until the consumer acknowledges it.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock_100,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  input  logic                  ack_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_ready
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  deser_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] shifted_s;

  assign shifted_s = {shift_q[DATA_WIDTH-2:0], data_in};

  // Next-state logic: bits only count in RECEIVE, ack only matters in READY.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    case (state_q)
      RECEIVE: begin
        if (write_in) begin
          shift_d = shifted_s;
          if (cnt_q == LAST_BIT) begin
            data_out_d = shifted_s;
            ready_d    = 1'b1;
            cnt_d      = '0;
            state_d    = READY;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      READY: begin
        if (ack_in) begin
          ready_d = 1'b0;
          shift_d = '0;
          state_d = RECEIVE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = RECEIVE;
        cnt_d   = '0;
        shift_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, counter, shift register and registered outputs.
  always_ff @(posedge clock_100) begin
    if (reset) begin
      state_q    <= RECEIVE;
      cnt_q      <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = ready_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer.
module tb_deserializer;

  logic       clock_100;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       data_ready;

  int errors;
  int checks;

  deserializer #(.DATA_WIDTH(8)) dut (
    .clock_100 (clock_100),
    .reset     (reset),
    .data_in   (data_in),
    .write_in  (write_in),
    .ack_in    (ack_in),
    .data_out  (data_out),
    .data_ready(data_ready)
  );

  initial clock_100 = 1'b0;
  always #5 clock_100 = ~clock_100;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_100);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    data_in  = b;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
    data_in  = 1'b0;
    if (gap) tick();
  endtask

  // Sends a word MSB first; data_ready must stay low until the final bit lands.
  task automatic send_word(input string tag, input logic [7:0] w, input bit gap);
    for (int i = 7; i >= 1; i--) send_bit(w[i], gap);
    chk({tag, "_ready_before_last"}, {7'd0, data_ready}, 8'h00);
    send_bit(w[0], 1'b0);
    chk({tag, "_data"}, data_out, w);
    chk({tag, "_ready"}, {7'd0, data_ready}, 8'h01);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    data_in  = 1'b0;
    write_in = 1'b0;
    ack_in   = 1'b0;
    tick();
    tick();
    chk("reset_data", data_out, 8'h00);
    chk("reset_ready", {7'd0, data_ready}, 8'h00);
    reset = 1'b0;
    tick();

    // Single-cycle pulses with idle gaps: 1,0,1,0,1,1,0,1 -> 0xAD
    send_word("ad", 8'hAD, 1'b1);

    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("ack_ready", {7'd0, data_ready}, 8'h00);
    chk("ack_data_hold", data_out, 8'hAD);
    tick();
    chk("post_ack_ready", {7'd0, data_ready}, 8'h00);

    // Back-to-back strobes
    send_word("3c", 8'h3C, 1'b0);
    tick();
    tick();
    chk("hold_data", data_out, 8'h3C);
    chk("hold_ready", {7'd0, data_ready}, 8'h01);

    // Bits while READY are dropped
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("drop_data", data_out, 8'h3C);
    chk("drop_ready", {7'd0, data_ready}, 8'h01);

    // Ack together with a write: ack wins, the bit is dropped
    ack_in   = 1'b1;
    write_in = 1'b1;
    data_in  = 1'b1;
    tick();
    ack_in   = 1'b0;
    write_in = 1'b0;
    data_in  = 1'b0;
    chk("ack_write_ready", {7'd0, data_ready}, 8'h00);
    send_word("5a", 8'h5A, 1'b0);

    // Ack held high for three cycles
    ack_in = 1'b1;
    tick();
    tick();
    tick();
    ack_in = 1'b0;
    chk("long_ack_ready", {7'd0, data_ready}, 8'h00);
    chk("long_ack_data", data_out, 8'h5A);

    // Partial word discarded by reset
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_data", data_out, 8'h00);
    chk("midreset_ready", {7'd0, data_ready}, 8'h00);
    send_word("f0", 8'hF0, 1'b0);

    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;

    // Ack in RECEIVE after 3 bits of 0x96 is ignored
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("rx_ack_ready", {7'd0, data_ready}, 8'h00);
    chk("rx_ack_data", data_out, 8'hF0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("rx_ack_ready_before_last", {7'd0, data_ready}, 8'h00);
    send_bit(1'b0, 1'b0);
    chk("96_data", data_out, 8'h96);
    chk("96_ready", {7'd0, data_ready}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
